// File: rtl/mem_lsu_pkg_ysyx_23060136.sv
`default_nettype none
// ============================================================================
// Module  : mem_lsu_pkg_ysyx_23060136
// Brief   : Shared types and constants for the MEM-stage load/store unit.
// Revision: 1.0 - initial release
// ============================================================================
package mem_lsu_pkg_ysyx_23060136;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AWW  = 3'd3,
        ST_B    = 3'd4,
        ST_DONE = 3'd5
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Flags are one-hot; an access with no size flag set is a word access.
    function automatic lsu_size_t size_from_flags(
        input logic is_byte,
        input logic is_half,
        input logic is_word,
        input logic is_byte_u,
        input logic is_half_u
    );
        if (is_word)
            return SZ_W;
        else if (is_half || is_half_u)
            return SZ_H;
        else if (is_byte || is_byte_u)
            return SZ_B;
        else
            return SZ_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_align_ysyx_23060136.sv
`default_nettype none
// ============================================================================
// Module  : mem_lsu_align_ysyx_23060136
// Brief   : Store lane placement, load extraction/extension, misalign check.
// Revision: 1.0 - initial release
// ============================================================================
module mem_lsu_align_ysyx_23060136
    import mem_lsu_pkg_ysyx_23060136::*;
(
    input  logic [1:0]  i_offset,
    input  lsu_size_t   i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_bus_rdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_misaligned
);

    logic [31:0] w_shifted;

    always_comb begin
        w_shifted    = i_bus_rdata >> {i_offset, 3'b000};
        o_wstrb      = 4'hF;
        o_wdata      = i_store_data;
        o_load_data  = w_shifted;
        o_misaligned = 1'b0;
        case (i_size)
            SZ_B: begin
                o_wstrb     = 4'b0001 << i_offset;
                o_wdata     = {4{i_store_data[7:0]}};
                o_load_data = i_unsigned ? {24'd0, w_shifted[7:0]}
                                         : {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            SZ_H: begin
                o_misaligned = i_offset[0];
                o_wstrb      = 4'b0011 << i_offset;
                o_wdata      = {2{i_store_data[15:0]}};
                o_load_data  = i_unsigned ? {16'd0, w_shifted[15:0]}
                                          : {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            default: begin
                o_misaligned = |i_offset;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_lsu_ysyx_23060136.sv
`default_nettype none
// ============================================================================
// Module  : mem_lsu_ysyx_23060136
// Brief   : MEM-stage load/store unit bridging EX/MEM to an AXI4-Lite master.
// Revision: 1.0 - initial release
// ============================================================================
module mem_lsu_ysyx_23060136
    import mem_lsu_pkg_ysyx_23060136::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_i_valid,
    output logic              MEM_o_ready,
    input  logic [ADDR_W-1:0] MEM_i_addr,
    input  logic [DATA_W-1:0] MEM_i_wdata,
    input  logic              MEM_i_write_mem,
    input  logic              MEM_i_mem_to_reg,
    input  logic              MEM_i_mem_byte,
    input  logic              MEM_i_mem_half,
    input  logic              MEM_i_mem_word,
    input  logic              MEM_i_mem_byte_u,
    input  logic              MEM_i_mem_half_u,
    output logic              MEM_o_valid,
    input  logic              MEM_i_ready,
    output logic [DATA_W-1:0] MEM_o_rdata,
    output logic              MEM_o_fault,
    output logic [ADDR_W-1:0] M_araddr,
    output logic              M_arvalid,
    input  logic              M_arready,
    input  logic [DATA_W-1:0] M_rdata,
    input  logic [1:0]        M_rresp,
    input  logic              M_rvalid,
    output logic              M_rready,
    output logic [ADDR_W-1:0] M_awaddr,
    output logic              M_awvalid,
    input  logic              M_awready,
    output logic [DATA_W-1:0] M_wdata,
    output logic [3:0]        M_wstrb,
    output logic              M_wvalid,
    input  logic              M_wready,
    input  logic [1:0]        M_bresp,
    input  logic              M_bvalid,
    output logic              M_bready
);

    lsu_state_t        r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    lsu_size_t         r_size;
    logic              r_unsigned, r_fault, r_aw_done, r_w_done;

    logic              w_is_mem, w_accept, w_misalign;
    lsu_size_t         w_in_size, w_size;
    logic [1:0]        w_offset;
    logic [3:0]        w_wstrb;
    logic [31:0]       w_wdata, w_load;

    assign w_is_mem  = MEM_i_write_mem | MEM_i_mem_to_reg;
    assign w_accept  = (r_state == ST_IDLE) && MEM_i_valid && w_is_mem;
    assign w_in_size = size_from_flags(MEM_i_mem_byte, MEM_i_mem_half, MEM_i_mem_word,
                                       MEM_i_mem_byte_u, MEM_i_mem_half_u);

    // In IDLE the aligner checks the incoming request; afterwards it works on the captured one.
    assign w_offset = (r_state == ST_IDLE) ? MEM_i_addr[1:0] : r_addr[1:0];
    assign w_size   = (r_state == ST_IDLE) ? w_in_size : r_size;

    mem_lsu_align_ysyx_23060136 u_align (
        .i_offset     (w_offset),
        .i_size       (w_size),
        .i_unsigned   (r_unsigned),
        .i_store_data (r_wdata),
        .i_bus_rdata  (M_rdata),
        .o_wstrb      (w_wstrb),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load),
        .o_misaligned (w_misalign)
    );

    assign M_araddr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign M_arvalid = (r_state == ST_AR);
    assign M_rready  = (r_state == ST_R);
    assign M_awaddr  = {r_addr[ADDR_W-1:2], 2'b00};
    assign M_awvalid = (r_state == ST_AWW) && !r_aw_done;
    assign M_wvalid  = (r_state == ST_AWW) && !r_w_done;
    assign M_wdata   = w_wdata;
    assign M_wstrb   = w_wstrb;
    assign M_bready  = (r_state == ST_B);

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        MEM_o_ready = 1'b0;
        MEM_o_valid = 1'b0;
        MEM_o_rdata = '0;
        MEM_o_fault = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_is_mem) begin
                    MEM_o_ready = 1'b1;
                    if (MEM_i_valid)
                        w_next = w_misalign      ? ST_DONE :
                                 MEM_i_write_mem ? ST_AWW  : ST_AR;
                end else begin
                    MEM_o_valid = MEM_i_valid;
                    MEM_o_ready = MEM_i_ready;
                end
            end
            ST_AR:   if (M_arready) w_next = ST_R;
            ST_R:    if (M_rvalid)  w_next = ST_DONE;
            ST_AWW:  if ((r_aw_done || M_awready) && (r_w_done || M_wready)) w_next = ST_B;
            ST_B:    if (M_bvalid)  w_next = ST_DONE;
            ST_DONE: begin
                MEM_o_valid = 1'b1;
                MEM_o_rdata = r_rdata;
                MEM_o_fault = r_fault;
                if (MEM_i_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_size     <= SZ_W;
            r_unsigned <= 1'b0;
            r_fault    <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr     <= MEM_i_addr;
                        r_wdata    <= MEM_i_wdata;
                        r_size     <= w_in_size;
                        r_unsigned <= MEM_i_mem_byte_u | MEM_i_mem_half_u;
                        r_rdata    <= '0;
                        r_fault    <= w_misalign;
                        r_aw_done  <= 1'b0;
                        r_w_done   <= 1'b0;
                    end
                end
                ST_R: begin
                    if (M_rvalid) begin
                        r_rdata <= w_load;
                        r_fault <= (M_rresp != RESP_OKAY);
                    end
                end
                ST_AWW: begin
                    if (M_awvalid && M_awready) r_aw_done <= 1'b1;
                    if (M_wvalid && M_wready)   r_w_done  <= 1'b1;
                end
                ST_B: begin
                    if (M_bvalid) r_fault <= (M_bresp != RESP_OKAY);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
